multi_pass_alu: RTL and testbench
=================================

MULTI_PASS_ALU -- requirements
Module: multi_pass_alu

Interface
REQ-001 SHALL have parameter SLICE_W, default 8, bits processed per pass.
REQ-002 SHALL have parameter LANES, default 2, maximum passes; operand width OP_W = SLICE_W*LANES.
REQ-003 SHALL have port i_Clk  in  1  system clock; sole clock, all state on rising edge.
REQ-004 SHALL have port i_Rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port i_Enable  in  1  clock enable; low freezes all state.
REQ-006 SHALL have port i_Start  in  1  request; sampled only when idle.
REQ-007 SHALL have port i_Op  in  4  operation: 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP, 8 DAA, 9-15 reserved.
REQ-008 SHALL have port i_Len  in  $clog2(LANES+1)  passes requested.
REQ-009 SHALL have ports i_A, i_B  in  OP_W  operands.
REQ-010 SHALL have port i_Save_Flags  in  1  commit flags on completion.
REQ-011 SHALL have ports i_Flags_Write  in  1 and i_Flags_Data  in  4  direct flag load.
REQ-012 SHALL have ports o_Busy  out  1; o_Done  out  1; o_Result  out  OP_W; o_Flags  out  4 ({Z,N,H,C}).

Function
REQ-013 States IDLE, RUN, DONE; IDLE->RUN on enabled i_Start; RUN->DONE after final pass; DONE->IDLE next enabled cycle.
REQ-014 Start latches i_Op, i_Len, i_A, i_B, i_Save_Flags; later input changes ignored until IDLE.
REQ-015 Effective length: i_Len=0 -> 1; i_Len>LANES -> LANES.
REQ-016 One SLICE_W slice per enabled RUN cycle, LSB slice first, carry/borrow chained between passes.
REQ-017 ADC/SBC carry-in of pass 0 = flag C at start; ADD/SUB/CP carry-in 0.
REQ-018 Z = 1 iff all result bits across all passes zero; N = 1 for SUB/SBC/CP/DAA-preserved; H = carry/borrow out of bit 3 of final slice; C = carry/borrow out of final slice.
REQ-019 AND: H=1, N=0, C=0; XOR/OR: N=H=C=0.
REQ-020 CP: o_Result = i_A; flags as SUB.
REQ-021 Unused upper o_Result slices (effective length < LANES) SHALL be zero.
REQ-022 o_Busy high in RUN and DONE; o_Done one-cycle pulse in DONE; o_Result held until next accepted start.
REQ-023 Latency: start accepted cycle 0, o_Done in cycle len+1 (enabled cycles).
REQ-024 Flags register updated in DONE only if latched i_Save_Flags; reserved ops: o_Result = i_A, flags never updated.
REQ-025 i_Flags_Write loads i_Flags_Data in any state; simultaneous with DONE commit, i_Flags_Write wins.
REQ-026 i_Start while busy ignored, no queuing.

Reset
REQ-027 Reset low: state IDLE, o_Busy=0, o_Done=0, o_Result=0, flags=0, immediately, including mid-operation (operation discarded).

Configuration
REQ-028 Macro MULTI_PASS_ALU_DAA_EN defined: op 8 SHALL decimal-adjust slice 0 per N/H/C flags (single pass regardless of i_Len), Z from result, H=0, C set if adjusted over 0x99, N preserved.
REQ-029 Macro undefined: op 8 SHALL behave as reserved (REQ-024); no DAA logic synthesized.

Structure
REQ-030 Shared package/header SHALL hold op encodings, flag bit indices {Z=3,N=2,H=1,C=0}, state encodings.
REQ-031 One combinational sub-module alu_slice (SLICE_W-bit add/sub/logic with carry-in, carry-out, half-carry) SHALL be instantiated once and reused per pass.

Verification (SLICE_W=8, LANES=2)
REQ-032 ADD len=2, A=0x0FFF, B=0x0001, save -> o_Result 0x1000, flags Z0 N0 H1 C0, o_Done at cycle 3.
REQ-033 SUB len=1, A=0x0005, B=0x0005 -> o_Result 0x0000, Z1 N1 H0 C0, o_Done at cycle 2.
REQ-034 Flags preload C=1, ADC len=2, A=0xFFFF, B=0 -> o_Result 0x0000, Z1 N0 H1 C1.
REQ-035 CP len=1, A=0x0010, B=0x0020, i_Save_Flags=0 -> o_Result 0x0010, o_Flags unchanged.
REQ-036 Reset asserted during second pass -> o_Busy=0, o_Done=0, o_Result=0, flags 0 same cycle; no later o_Done.
REQ-037 DAA A=0x009A, flags 0: with macro -> o_Result 0x0000, Z1 C1 H0; without -> o_Result 0x009A, flags unchanged.

Source files
------------

// File: rtl/multi_pass_alu_pkg.sv
// Shared definitions for multi_pass_alu: op codes, flag bit indices,
// FSM states and the per-slice function selector.
// Optional DAA support is enabled by defining MULTI_PASS_ALU_DAA_EN.
package multi_pass_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_CP  = 4'd7;
    localparam logic [3:0] OP_DAA = 4'd8;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        FN_ADD = 3'd0,
        FN_SUB = 3'd1,
        FN_AND = 3'd2,
        FN_XOR = 3'd3,
        FN_OR  = 3'd4
    } fn_e;

    // Reserved ops pass A through and never touch the flags.
    function automatic logic is_reserved(input logic [3:0] op);
`ifdef MULTI_PASS_ALU_DAA_EN
        return op > OP_DAA;
`else
        return op > OP_CP;
`endif
    endfunction

    function automatic fn_e op_fn(input logic [3:0] op);
        fn_e fn;
        unique case (op)
            OP_ADD, OP_ADC:        fn = FN_ADD;
            OP_SUB, OP_SBC, OP_CP: fn = FN_SUB;
            OP_AND:                fn = FN_AND;
            OP_XOR:                fn = FN_XOR;
            OP_OR:                 fn = FN_OR;
            default:               fn = FN_ADD;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/multi_pass_alu_alu_slice.sv
// One W-bit ALU slice: add/sub with carry (borrow) in/out and bit-3
// half carry, plus AND/XOR/OR. Ports: i_Fn, i_A, i_B, i_Cin -> o_Y, o_Cout, o_Half.
module alu_slice
    import multi_pass_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  fn_e          i_Fn,
    input  logic [W-1:0] i_A,
    input  logic [W-1:0] i_B,
    input  logic         i_Cin,
    output logic [W-1:0] o_Y,
    output logic         o_Cout,
    output logic         o_Half
);

    logic [W:0] full;
    logic [4:0] nib;

    always_comb begin
        full   = '0;
        nib    = '0;
        o_Y    = '0;
        o_Cout = 1'b0;
        o_Half = 1'b0;
        unique case (i_Fn)
            FN_ADD: begin
                full = {1'b0, i_A} + {1'b0, i_B} + {{W{1'b0}}, i_Cin};
                nib  = {1'b0, i_A[3:0]} + {1'b0, i_B[3:0]} + {4'b0, i_Cin};
                o_Y    = full[W-1:0];
                o_Cout = full[W];
                o_Half = nib[4];
            end
            FN_SUB: begin
                // Bit W / bit 4 of the wrapped difference is the borrow.
                full = {1'b0, i_A} - {1'b0, i_B} - {{W{1'b0}}, i_Cin};
                nib  = {1'b0, i_A[3:0]} - {1'b0, i_B[3:0]} - {4'b0, i_Cin};
                o_Y    = full[W-1:0];
                o_Cout = full[W];
                o_Half = nib[4];
            end
            FN_AND: o_Y = i_A & i_B;
            FN_XOR: o_Y = i_A ^ i_B;
            FN_OR:  o_Y = i_A | i_B;
            default: o_Y = '0;
        endcase
    end

endmodule

// File: rtl/multi_pass_alu.sv
// Multi-pass ALU: processes OP_W-bit operands one SLICE_W slice per
// enabled cycle through a single alu_slice, chaining carry between passes.
// Ports: i_Clk, i_Rst_n (async low), i_Enable, i_Start, i_Op, i_Len, i_A,
// i_B, i_Save_Flags, i_Flags_Write, i_Flags_Data -> o_Busy, o_Done,
// o_Result, o_Flags {Z,N,H,C}. Define MULTI_PASS_ALU_DAA_EN for op 8 (DAA).
module multi_pass_alu
    import multi_pass_alu_pkg::*;
#(
    parameter  int SLICE_W = 8,
    parameter  int LANES   = 2,
    localparam int OP_W    = SLICE_W * LANES,
    localparam int LEN_W   = $clog2(LANES + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Enable,
    input  logic             i_Start,
    input  logic [3:0]       i_Op,
    input  logic [LEN_W-1:0] i_Len,
    input  logic [OP_W-1:0]  i_A,
    input  logic [OP_W-1:0]  i_B,
    input  logic             i_Save_Flags,
    input  logic             i_Flags_Write,
    input  logic [3:0]       i_Flags_Data,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [OP_W-1:0]  o_Result,
    output logic [3:0]       o_Flags
);

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] pass_q, pass_d;
    logic [OP_W-1:0]  a_q, a_d;
    logic [OP_W-1:0]  b_q, b_d;
    logic             save_q, save_d;
    logic             carry_q, carry_d;
    logic             half_q, half_d;
    logic             zero_q, zero_d;
    logic [OP_W-1:0]  result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [LEN_W-1:0]   eff_len;
    int                 slice_lsb;
    fn_e                slice_fn;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_y;
    logic               slice_cin, slice_cout, slice_half;
    logic [3:0]         done_flags;

`ifdef MULTI_PASS_ALU_DAA_EN
    localparam logic [SLICE_W-1:0] DAA_LIM = SLICE_W'(8'h99);
    localparam logic [SLICE_W-1:0] DAA_HI  = SLICE_W'(8'h60);
    localparam logic [SLICE_W-1:0] DAA_LO  = SLICE_W'(8'h06);

    // N/H/C snapshot at start steers the decimal correction.
    logic [2:0]         nhc_q, nhc_d;
    logic [SLICE_W-1:0] daa_corr;
    logic               daa_c;

    always_comb begin
        daa_corr = '0;
        daa_c    = nhc_q[FLAG_C];
        if (!nhc_q[FLAG_N]) begin
            if (nhc_q[FLAG_C] || a_q[SLICE_W-1:0] > DAA_LIM) begin
                daa_corr = daa_corr | DAA_HI;
                daa_c    = 1'b1;
            end
            if (nhc_q[FLAG_H] || a_q[3:0] > 4'd9) begin
                daa_corr = daa_corr | DAA_LO;
            end
        end else begin
            if (nhc_q[FLAG_C]) daa_corr = daa_corr | DAA_HI;
            if (nhc_q[FLAG_H]) daa_corr = daa_corr | DAA_LO;
        end
    end
`endif

    always_comb begin
        if (i_Len == '0) begin
            eff_len = LEN_W'(1);
        end else if (i_Len > LEN_W'(LANES)) begin
            eff_len = LEN_W'(LANES);
        end else begin
            eff_len = i_Len;
        end
    end

    assign slice_lsb = int'(pass_q) * SLICE_W;
    assign slice_a   = a_q[slice_lsb +: SLICE_W];

    always_comb begin
        slice_fn  = op_fn(op_q);
        slice_b   = b_q[slice_lsb +: SLICE_W];
        slice_cin = carry_q;
`ifdef MULTI_PASS_ALU_DAA_EN
        if (op_q == OP_DAA) begin
            slice_fn  = nhc_q[FLAG_N] ? FN_SUB : FN_ADD;
            slice_b   = daa_corr;
            slice_cin = 1'b0;
        end
`endif
    end

    alu_slice #(.W(SLICE_W)) u_slice (
        .i_Fn   (slice_fn),
        .i_A    (slice_a),
        .i_B    (slice_b),
        .i_Cin  (slice_cin),
        .o_Y    (slice_y),
        .o_Cout (slice_cout),
        .o_Half (slice_half)
    );

    always_comb begin
        done_flags         = '0;
        done_flags[FLAG_Z] = zero_q;
        unique case (op_q)
            OP_ADD, OP_ADC: begin
                done_flags[FLAG_H] = half_q;
                done_flags[FLAG_C] = carry_q;
            end
            OP_SUB, OP_SBC, OP_CP: begin
                done_flags[FLAG_N] = 1'b1;
                done_flags[FLAG_H] = half_q;
                done_flags[FLAG_C] = carry_q;
            end
            OP_AND: done_flags[FLAG_H] = 1'b1;
`ifdef MULTI_PASS_ALU_DAA_EN
            OP_DAA: begin
                done_flags[FLAG_N] = nhc_q[FLAG_N];
                done_flags[FLAG_C] = carry_q;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        len_d    = len_q;
        pass_d   = pass_q;
        a_d      = a_q;
        b_d      = b_q;
        save_d   = save_q;
        carry_d  = carry_q;
        half_d   = half_q;
        zero_d   = zero_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef MULTI_PASS_ALU_DAA_EN
        nhc_d    = nhc_q;
`endif
        if (i_Enable) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_Start) begin
                        state_d  = ST_RUN;
                        op_d     = i_Op;
                        len_d    = eff_len;
                        pass_d   = '0;
                        a_d      = i_A;
                        b_d      = i_B;
                        save_d   = i_Save_Flags;
                        carry_d  = (i_Op == OP_ADC || i_Op == OP_SBC)
                                   && flags_q[FLAG_C];
                        half_d   = 1'b0;
                        zero_d   = 1'b1;
                        result_d = is_reserved(i_Op) ? i_A : '0;
`ifdef MULTI_PASS_ALU_DAA_EN
                        nhc_d    = flags_q[2:0];
                        if (i_Op == OP_DAA) len_d = LEN_W'(1);
`endif
                    end
                end
                ST_RUN: begin
                    if (!is_reserved(op_q)) begin
                        result_d[slice_lsb +: SLICE_W] =
                            (op_q == OP_CP) ? slice_a : slice_y;
                        zero_d  = zero_q & (slice_y == '0);
                        carry_d = slice_cout;
                        half_d  = slice_half;
`ifdef MULTI_PASS_ALU_DAA_EN
                        if (op_q == OP_DAA) carry_d = daa_c;
`endif
                    end
                    pass_d = pass_q + LEN_W'(1);
                    if (pass_d == len_q) state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    if (save_q && !is_reserved(op_q)) flags_d = done_flags;
                end
                default: state_d = ST_IDLE;
            endcase
            if (i_Flags_Write) flags_d = i_Flags_Data;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            len_q    <= '0;
            pass_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            save_q   <= 1'b0;
            carry_q  <= 1'b0;
            half_q   <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
`ifdef MULTI_PASS_ALU_DAA_EN
            nhc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            len_q    <= len_d;
            pass_q   <= pass_d;
            a_q      <= a_d;
            b_q      <= b_d;
            save_q   <= save_d;
            carry_q  <= carry_d;
            half_q   <= half_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef MULTI_PASS_ALU_DAA_EN
            nhc_q    <= nhc_d;
`endif
        end
    end

    assign o_Busy   = (state_q != ST_IDLE);
    assign o_Done   = (state_q == ST_DONE);
    assign o_Result = result_q;
    assign o_Flags  = flags_q;

endmodule

// File: tb/tb_multi_pass_alu.sv
// Self-checking bench for multi_pass_alu (SLICE_W=8, LANES=2): directed
// cases with literal expectations plus randomized traffic vs. a model.
module tb_multi_pass_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_Enable, i_Start, i_Save_Flags, i_Flags_Write;
    logic [3:0]  i_Op, i_Flags_Data;
    logic [1:0]  i_Len;
    logic [15:0] i_A, i_B;
    logic        o_Busy, o_Done;
    logic [15:0] o_Result;
    logic [3:0]  o_Flags;

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model state.
    bit          m_busy, m_done, m_commit;
    int          m_left;
    logic [3:0]  m_flags, m_pend_f;
    logic [15:0] m_result, m_pend_r;

    always #5 clk = ~clk;

    multi_pass_alu dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_Enable     (i_Enable),
        .i_Start      (i_Start),
        .i_Op         (i_Op),
        .i_Len        (i_Len),
        .i_A          (i_A),
        .i_B          (i_B),
        .i_Save_Flags (i_Save_Flags),
        .i_Flags_Write(i_Flags_Write),
        .i_Flags_Data (i_Flags_Data),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
        .o_Result     (o_Result),
        .o_Flags      (o_Flags)
    );

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

`ifdef MULTI_PASS_ALU_DAA_EN
    localparam bit DAA_ON = 1'b1;
`else
    localparam bit DAA_ON = 1'b0;
`endif

    function automatic int eff_len(input logic [3:0] op,
                                   input logic [1:0] len);
        if (DAA_ON && op == 4'd8) return 1;
        if (len == 2'd0) return 1;
        if (len > 2'd2) return 2;
        return int'(len);
    endfunction

    // Whole-operand arithmetic over the low 8*n bits.
    function automatic void ref_op(input logic [3:0] op, input int n,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] f,
                                   output logic [15:0] r,
                                   output logic [3:0] nf,
                                   output bit resv);
        longint am, bm, mask, lom, s, cin, cf, a0, corr;
        int w, lo;
        bit h, c;
        w = 8 * n;
        lo = w - 8;
        mask = (longint'(1) << w) - 1;
        lom = (longint'(1) << lo) - 1;
        am = longint'(a) & mask;
        bm = longint'(b) & mask;
        cin = (op == 4'd1 || op == 4'd3) ? longint'(f[0]) : 0;
        resv = 1'b0;
        r = a;
        nf = f;
        if (op <= 4'd1) begin
            s = am + bm + cin;
            cf = (n > 1) ? (((am & lom) + (bm & lom) + cin) >> lo) & 1 : cin;
            h = (((am >> lo) & 15) + ((bm >> lo) & 15) + cf) > 15;
            c = s > mask;
            r = 16'(s & mask);
            nf = {r == 16'd0, 1'b0, h, c};
        end else if (op <= 4'd3 || op == 4'd7) begin
            s = am - bm - cin;
            cf = (n > 1) ? ((((am & lom) - (bm & lom) - cin) < 0) ? 1 : 0)
                         : cin;
            h = (((am >> lo) & 15) - ((bm >> lo) & 15) - cf) < 0;
            c = s < 0;
            r = (op == 4'd7) ? 16'(am) : 16'(s & mask);
            nf = {(s & mask) == 0, 1'b1, h, c};
        end else if (op == 4'd4) begin
            r = 16'(am & bm);
            nf = {r == 16'd0, 3'b010};
        end else if (op == 4'd5) begin
            r = 16'(am ^ bm);
            nf = {r == 16'd0, 3'b000};
        end else if (op == 4'd6) begin
            r = 16'(am | bm);
            nf = {r == 16'd0, 3'b000};
        end else if (op == 4'd8 && DAA_ON) begin
            a0 = longint'(a) & 255;
            corr = 0;
            c = f[0];
            if (!f[2]) begin
                if (f[0] || a0 > 153) begin corr += 96; c = 1'b1; end
                if (f[1] || (a0 & 15) > 9) corr += 6;
                r = 16'((a0 + corr) & 255);
            end else begin
                if (f[0]) corr += 96;
                if (f[1]) corr += 6;
                r = 16'((a0 - corr) & 255);
            end
            nf = {r == 16'd0, f[2], 1'b0, c};
        end else begin
            resv = 1'b1;
        end
    endfunction

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_commit = 0; m_left = 0;
        m_flags = '0; m_result = '0; m_pend_r = '0; m_pend_f = '0;
    endtask

    task automatic model_edge();
        logic [3:0] nf;
        bit resv;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!i_Enable) return;
        nf = m_flags;
        if (m_done) begin
            if (m_commit) nf = m_pend_f;
            m_done = 0;
            m_busy = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_result = m_pend_r;
            end
        end else if (i_Start) begin
            m_left = eff_len(i_Op, i_Len);
            ref_op(i_Op, m_left, i_A, i_B, m_flags, m_pend_r, m_pend_f, resv);
            m_commit = i_Save_Flags && !resv;
            m_busy = 1;
        end
        if (i_Flags_Write) nf = i_Flags_Data;
        m_flags = nf;
    endtask

    task automatic compare_all();
        chk("busy", o_Busy, m_busy);
        chk("done", o_Done, m_done);
        chk("flags", o_Flags, m_flags);
        if (!m_busy || m_done) chk("result", o_Result, m_result);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_flags(input logic [3:0] v);
        i_Flags_Write = 1'b1;
        i_Flags_Data = v;
        cycle();
        i_Flags_Write = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [3:0] op,
                            input logic [1:0] len, input logic [15:0] a,
                            input logic [15:0] b, input bit save,
                            input bit fw, input logic [3:0] fd,
                            input logic [15:0] exp_r, input logic [3:0] exp_f,
                            input int exp_lat);
        int lat;
        i_Enable = 1'b1;
        i_Start = 1'b1;
        i_Op = op;
        i_Len = len;
        i_A = a;
        i_B = b;
        i_Save_Flags = save;
        cycle();
        // Inputs that change after acceptance must be ignored.
        i_Start = 1'b0;
        i_Op = 4'd15;
        i_A = ~a;
        i_B = ~b;
        i_Save_Flags = ~save;
        lat = 1;
        while (!o_Done && lat < 20) begin
            cycle();
            lat++;
        end
        chk({nm, "_lat"}, lat, exp_lat);
        chk({nm, "_res"}, o_Result, exp_r);
        if (fw) begin
            i_Flags_Write = 1'b1;
            i_Flags_Data = fd;
        end
        cycle();
        i_Flags_Write = 1'b0;
        chk({nm, "_flg"}, o_Flags, exp_f);
    endtask

    initial begin
        rst_n = 1'b0;
        i_Enable = 1'b0; i_Start = 1'b0; i_Op = '0; i_Len = '0;
        i_A = '0; i_B = '0; i_Save_Flags = 1'b0;
        i_Flags_Write = 1'b0; i_Flags_Data = '0;
        model_reset();
        #2;
        compare_all();
        chk("rst_res", o_Result, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        i_Enable = 1'b1;
        cycle();

        directed("add", 4'd0, 2'd2, 16'h0FFF, 16'h0001, 1, 0, 4'h0,
                 16'h1000, 4'b0010, 3);
        directed("sub", 4'd2, 2'd1, 16'h0005, 16'h0005, 1, 0, 4'h0,
                 16'h0000, 4'b1100, 2);
        set_flags(4'b0001);
        directed("adc", 4'd1, 2'd2, 16'hFFFF, 16'h0000, 1, 0, 4'h0,
                 16'h0000, 4'b1011, 3);
        directed("cp", 4'd7, 2'd1, 16'h0010, 16'h0020, 0, 0, 4'h0,
                 16'h0010, 4'b1011, 2);
        set_flags(4'b0000);
        if (DAA_ON)
            directed("daa", 4'd8, 2'd2, 16'h009A, 16'h0000, 1, 0, 4'h0,
                     16'h0000, 4'b1001, 2);
        else
            directed("daa", 4'd8, 2'd2, 16'h009A, 16'h0000, 1, 0, 4'h0,
                     16'h009A, 4'b0000, 3);
        directed("len3", 4'd0, 2'd3, 16'h00FF, 16'h0001, 1, 0, 4'h0,
                 16'h0100, 4'b0000, 3);
        directed("len0", 4'd0, 2'd0, 16'h12FF, 16'h0001, 1, 0, 4'h0,
                 16'h0000, 4'b1011, 2);
        directed("fwin", 4'd4, 2'd1, 16'h000F, 16'h00F0, 1, 1, 4'b0110,
                 16'h0000, 4'b0110, 2);
        directed("rsv", 4'd12, 2'd2, 16'hBEEF, 16'h1111, 1, 0, 4'h0,
                 16'hBEEF, 4'b0110, 3);

        // Reset in the middle of the second pass.
        set_flags(4'b1010);
        i_Start = 1'b1; i_Op = 4'd0; i_Len = 2'd2;
        i_A = 16'h1234; i_B = 16'h1111; i_Save_Flags = 1'b1;
        cycle();
        i_Start = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("mid_rst_busy", o_Busy, 1'b0);
        chk("mid_rst_res", o_Result, 16'h0);
        chk("mid_rst_flg", o_Flags, 4'h0);
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        for (int i = 0; i < 800; i++) begin
            i_Enable = ($urandom % 8) != 0;
            i_Start = ($urandom % 3) == 0;
            i_Op = (($urandom % 4) == 0) ? 4'($urandom % 16)
                                         : 4'($urandom % 9);
            i_Len = 2'($urandom % 4);
            i_A = 16'($urandom);
            i_B = 16'($urandom);
            i_Save_Flags = 1'($urandom % 2);
            i_Flags_Write = ($urandom % 10) == 0;
            i_Flags_Data = 4'($urandom);
            cycle();
        end
        i_Enable = 1'b1;
        i_Start = 1'b0;
        i_Flags_Write = 1'b0;
        for (int i = 0; i < 8; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
